// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t : sequencer states (IDLE waits for a request, RUN walks digits)
//   DIGIT_W : width of one digit handled by the comparator cell per cycle
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIGIT_W = 2;

endpackage

// File: rtl/comparator.sv
// 2-bit unsigned magnitude comparator cell, purely combinational.
// Ports:
//   i_a, i_b : 2-bit unsigned digits
//   o_gt     : i_a >  i_b
//   o_eq     : i_a == i_b
//   o_lt     : i_a <  i_b
// Exactly one output is high for any input combination.
module comparator
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  output logic               o_gt,
  output logic               o_eq,
  output logic               o_lt
);

  always_comb begin
    o_gt = (i_a > i_b);
    o_eq = (i_a == i_b);
    o_lt = (i_a < i_b);
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial unsigned magnitude comparator sequencer.
// Compares two WIDTH-bit operands one 2-bit digit per cycle, MSB first,
// through a single shared comparator cell, and stops at the first unequal
// digit. All outputs are registered.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : request, accepted only while not busy
//   a, b       : unsigned operands, captured on an accepted start
//   busy       : comparison in progress
//   done       : one-cycle pulse, result valid
//   a_gt_b, a_eq_b, a_lt_b : one-hot result, held until the next accepted start
//   cycles     : digits examined for the last result (1..DIGITS)
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = WIDTH / 2,
  localparam int CW     = $clog2(DIGITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [CW-1:0]    cycles
);

  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [CW-1:0]    r_cycles;

  state_t           w_state;
  logic [WIDTH-1:0] w_sa;
  logic [WIDTH-1:0] w_sb;
  logic [CW-1:0]    w_cnt;
  logic             w_busy;
  logic             w_done;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic [CW-1:0]    w_cycles;

  logic             w_slice_gt;
  logic             w_slice_eq;
  logic             w_slice_lt;

  // The cell always looks at the current top digit; the shift registers
  // move the next digit into that position after each equal digit.
  comparator u_slice (
    .i_a  (r_sa[WIDTH-1 -: DIGIT_W]),
    .i_b  (r_sb[WIDTH-1 -: DIGIT_W]),
    .o_gt (w_slice_gt),
    .o_eq (w_slice_eq),
    .o_lt (w_slice_lt)
  );

  always_comb begin
    w_state  = r_state;
    w_sa     = r_sa;
    w_sb     = r_sb;
    w_cnt    = r_cnt;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_gt     = r_gt;
    w_eq     = r_eq;
    w_lt     = r_lt;
    w_cycles = r_cycles;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_sa    = a;
          w_sb    = b;
          w_cnt   = '0;
          w_gt    = 1'b0;
          w_eq    = 1'b0;
          w_lt    = 1'b0;
          w_busy  = 1'b1;
          w_state = RUN;
        end
      end
      RUN: begin
        if (w_slice_eq && (r_cnt == LAST_DIGIT)) begin
          // Every digit matched: operands are equal.
          w_eq     = 1'b1;
          w_cycles = CW'(DIGITS);
          w_done   = 1'b1;
          w_busy   = 1'b0;
          w_state  = IDLE;
        end else if (w_slice_eq) begin
          w_sa  = r_sa << DIGIT_W;
          w_sb  = r_sb << DIGIT_W;
          w_cnt = r_cnt + CW'(1);
        end else begin
          // First unequal digit from the MSB decides the whole compare.
          w_gt     = w_slice_gt;
          w_lt     = w_slice_lt;
          w_eq     = 1'b0;
          w_cycles = r_cnt + CW'(1);
          w_done   = 1'b1;
          w_busy   = 1'b0;
          w_state  = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state;
      r_sa     <= w_sa;
      r_sb     <= w_sb;
      r_cnt    <= w_cnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_gt     <= w_gt;
      r_eq     <= w_eq;
      r_lt     <= w_lt;
      r_cycles <= w_cycles;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign a_gt_b = r_gt;
  assign a_eq_b = r_eq;
  assign a_lt_b = r_lt;
  assign cycles = r_cycles;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl (WIDTH=8): directed cases followed by
// randomized requests, reset pulses and requests issued while busy.
module tb_serial_cmp_ctrl;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS) + 1;

  typedef struct {
    int   acc_edge;
    int   done_edge;
    logic gt;
    logic eq;
    logic lt;
    int   ncyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, a_gt_b, a_eq_b, a_lt_b;
  logic [CW-1:0]    cycles;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   next_free = 0;
  exp_t q[$];

  // Last delivered result, held by the DUT between done and the next start.
  logic last_gt = 0, last_eq = 0, last_lt = 0;
  int   last_cyc = 0;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b),
    .cycles (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: flags from a full-width compare, digit count from the
  // position of the first differing 2-bit digit counted from the MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    int   n;
    n = DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
      int sh;
      sh = WIDTH - 2 - 2 * i;
      if (((x >> sh) & 2'b11) != ((y >> sh) & 2'b11)) begin
        n = i + 1;
        break;
      end
    end
    e.gt = (x > y);
    e.eq = (x == y);
    e.lt = (x < y);
    e.ncyc = n;
    e.acc_edge = 0;
    e.done_edge = 0;
    return e;
  endfunction

  // Drives one cycle of inputs, sampled by the next rising edge.
  task automatic drive(input logic s, input logic [WIDTH-1:0] xa,
                       input logic [WIDTH-1:0] xb, input logic rn);
    int   k;
    exp_t e;
    @(negedge clk);
    start = s;
    a     = xa;
    b     = xb;
    rst_n = rn;
    k = cyc + 1;
    if (!rn) begin
      q.delete();
      next_free = k + 1;
    end else if (s && k >= next_free) begin
      e = model(xa, xb);
      e.acc_edge  = k;
      e.done_edge = k + e.ncyc;
      q.push_back(e);
      next_free = k + e.ncyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'b1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      logic busy_exp;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {a_gt_b, a_eq_b, a_lt_b}, 0);
        check("rst_cycles", cycles, 0);
        last_gt = 0; last_eq = 0; last_lt = 0; last_cyc = 0;
      end else begin
        if (q.size() > 0 && q[0].done_edge < cyc) begin
          check("done_timeout", 0, 1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].done_edge == cyc) begin
          exp_t e;
          e = q.pop_front();
          check("done", done, 1);
          check("a_gt_b", a_gt_b, e.gt);
          check("a_eq_b", a_eq_b, e.eq);
          check("a_lt_b", a_lt_b, e.lt);
          check("cycles", cycles, e.ncyc);
          last_gt = e.gt; last_eq = e.eq; last_lt = e.lt; last_cyc = e.ncyc;
        end else begin
          check("no_done", done, 0);
        end
        busy_exp = (q.size() > 0 && q[0].acc_edge <= cyc);
        check("busy", busy, busy_exp);
        if (busy_exp) begin
          check("flags_busy", {a_gt_b, a_eq_b, a_lt_b}, 0);
        end else begin
          check("flags_hold", {a_gt_b, a_eq_b, a_lt_b}, {last_gt, last_eq, last_lt});
          check("cycles_hold", cycles, last_cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [WIDTH-1:0] ra, rb;

    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    idle(2);

    // Single-digit decision, then a decision on the last digit.
    drive(1, 8'hC3, 8'h43, 1); idle(4);
    drive(1, 8'h5A, 8'h5B, 1); idle(6);
    // Equal operands run all digits.
    drive(1, 8'hE7, 8'hE7, 1); idle(6);
    drive(1, 8'h00, 8'h00, 1); idle(6);
    drive(1, 8'hFF, 8'hFF, 1); idle(6);

    // Request while busy is ignored.
    drive(1, 8'h10, 8'h20, 1);
    drive(1, 8'hFF, 8'h00, 1);
    idle(5);

    // Reset in the second RUN cycle discards the comparison.
    drive(1, 8'h55, 8'h55, 1);
    drive(0, 8'h55, 8'h55, 1);
    drive(0, 8'h55, 8'h55, 0);
    idle(3);
    drive(1, 8'h01, 8'h02, 1); idle(6);

    // Back-to-back: new request presented in the done cycle.
    drive(1, 8'h80, 8'h40, 1);
    drive(1, 8'h80, 8'h40, 1);
    drive(1, 8'h40, 8'h80, 1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      ra = r[WIDTH-1:0];
      r  = $urandom;
      case (r[1:0])
        2'd0: rb = ra;
        2'd1: rb = ra ^ (WIDTH'(r[3:2] + 1) << (2 * (r[7:4] % DIGITS)));
        default: rb = r[WIDTH+7:8];
      endcase
      if (r[31:26] == 6'd0) drive(0, ra, rb, 0);
      else drive(r[25] | r[24], ra, rb, 1);
    end

    idle(3 * DIGITS);
    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
